// File: rtl/alt_vipcti131_common_flow_control_output.sv
// VIP output flow control: core write/stall beats to Avalon-ST packets through a small FIFO.
// Optional control-packet path built when VIP_FLOW_CONTROL_OUTPUT_CTRL_PKT_EN is defined.
module alt_vipcti131_common_flow_control_output #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_out,
    input  logic                                        write,
    input  logic                                        end_of_video_out,
    input  logic [15:0]                                 width_out,
    input  logic [15:0]                                 height_out,
    input  logic [3:0]                                  interlaced_out,
    input  logic                                        vip_ctrl_send,
    output logic                                        stall_out,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
    output logic                                        dout_valid,
    input  logic                                        dout_ready,
    output logic                                        dout_startofpacket,
    output logic                                        dout_endofpacket
);
    localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = DW + 2;

`ifdef VIP_FLOW_CONTROL_OUTPUT_CTRL_PKT_EN
    localparam int CTRL_BEATS = (9 + SYMBOLS_PER_BEAT - 1) / SYMBOLS_PER_BEAT;
    typedef enum logic [2:0] {IDLE, CTRL_HDR, CTRL_DATA, VID_HDR, VIDEO} state_t;
`else
    typedef enum logic [2:0] {IDLE, VID_HDR, VIDEO} state_t;
`endif

    state_t state_q;

    logic [FIFO_DEPTH-1:0][EW-1:0] mem_q;
    logic [AW-1:0]                 wr_q, rd_q;
    logic [AW:0]                   count_q;
    logic                          full, push, pop;
    logic [EW-1:0]                 push_entry, head;

    assign full       = (count_q == (AW+1)'(FIFO_DEPTH));
    assign dout_valid = (count_q != '0);
    assign pop        = dout_valid & dout_ready;
    assign stall_out  = (state_q != VIDEO) | full;

    // Gate the head so an empty FIFO presents all-zero outputs.
    assign head               = mem_q[rd_q];
    assign dout_data          = dout_valid ? head[DW-1:0] : '0;
    assign dout_endofpacket   = dout_valid & head[DW];
    assign dout_startofpacket = dout_valid & head[DW+1];

`ifdef VIP_FLOW_CONTROL_OUTPUT_CTRL_PKT_EN
    logic [15:0]   width_q, height_q;
    logic [3:0]    interlaced_q;
    logic [3:0]    nib_q;
    logic [DW-1:0] ctrl_beat;
    logic [35:0]   fields_all, fields_sh;
    int            idx;
    logic          ctrl_last;

    assign fields_all = {width_q, height_q, interlaced_q};
    assign ctrl_last  = (nib_q == 4'(CTRL_BEATS - 1));

    // Nibble k of the field stream lands in symbol (k mod S) of beat k/S.
    always_comb begin
        ctrl_beat = '0;
        fields_sh = '0;
        idx       = 0;
        for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
            idx = int'(nib_q) * SYMBOLS_PER_BEAT + s;
            if (idx < 9) begin
                fields_sh = fields_all << (4 * idx);
                ctrl_beat[s*BITS_PER_SYMBOL +: 4] = fields_sh[35:32];
            end
        end
    end
`else
    logic unused_ctrl;
    assign unused_ctrl = ^{vip_ctrl_send, width_out, height_out, interlaced_out};
`endif

    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        case (state_q)
`ifdef VIP_FLOW_CONTROL_OUTPUT_CTRL_PKT_EN
            CTRL_HDR: begin
                push       = ~full;
                push_entry = {1'b1, 1'b0, {(DW-4){1'b0}}, 4'hF};
            end
            CTRL_DATA: begin
                push       = ~full;
                push_entry = {1'b0, ctrl_last, ctrl_beat};
            end
`endif
            VID_HDR: begin
                push       = ~full;
                push_entry = {1'b1, 1'b0, {DW{1'b0}}};
            end
            VIDEO: begin
                push       = write & ~full;
                push_entry = {1'b0, end_of_video_out, data_out};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
`ifdef VIP_FLOW_CONTROL_OUTPUT_CTRL_PKT_EN
            nib_q        <= '0;
            width_q      <= '0;
            height_q     <= '0;
            interlaced_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef VIP_FLOW_CONTROL_OUTPUT_CTRL_PKT_EN
                    if (vip_ctrl_send) begin
                        width_q      <= width_out;
                        height_q     <= height_out;
                        interlaced_q <= interlaced_out;
                        state_q      <= CTRL_HDR;
                    end else if (write) begin
                        state_q <= VID_HDR;
                    end
`else
                    if (write) state_q <= VID_HDR;
`endif
                end
`ifdef VIP_FLOW_CONTROL_OUTPUT_CTRL_PKT_EN
                CTRL_HDR: if (!full) begin
                    nib_q   <= '0;
                    state_q <= CTRL_DATA;
                end
                CTRL_DATA: if (!full) begin
                    if (ctrl_last) state_q <= IDLE;
                    else           nib_q   <= nib_q + 4'd1;
                end
`endif
                VID_HDR: if (!full) state_q <= VIDEO;
                VIDEO: if (write && !full && end_of_video_out) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: validity is carried by count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_entry;
    end
endmodule
